// File: rtl/branch_resolution_queue_if.sv
// Shared branch-outcome type and the decode/execute/predictor port bundle
// of the branch resolution queue.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package brq_pkg;
    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;
endpackage

interface branch_resolution_queue_if #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
);
    import brq_pkg::*;

    // decode allocation
    logic                     i_alloc_valid;
    logic [`ADDR_WIDTH-1:0]   i_alloc_pc;
    BranchOutcome             i_alloc_prediction;
    logic [`ADDR_WIDTH-1:0]   i_alloc_recovery_target;
    logic                     o_alloc_ready;
    logic [TAG_W-1:0]         o_alloc_tag;
    // execute resolution
    logic                     i_res_valid;
    logic [TAG_W-1:0]         i_res_tag;
    BranchOutcome             i_res_outcome;
    // squash
    logic                     i_flush;
    // predictor feedback and redirect
    logic                     o_fb_valid;
    logic [`ADDR_WIDTH-1:0]   o_fb_pc;
    BranchOutcome             o_fb_prediction;
    BranchOutcome             o_fb_outcome;
    logic                     o_redirect_valid;
    logic [`ADDR_WIDTH-1:0]   o_redirect_target;
    // status
    logic [TAG_W:0]           o_count;
    logic [31:0]              o_retired_count;
    logic [31:0]              o_mispredict_count;

    modport master (
        output i_alloc_valid, i_alloc_pc, i_alloc_prediction, i_alloc_recovery_target,
        output i_res_valid, i_res_tag, i_res_outcome, i_flush,
        input  o_alloc_ready, o_alloc_tag, o_fb_valid, o_fb_pc, o_fb_prediction,
        input  o_fb_outcome, o_redirect_valid, o_redirect_target, o_count,
        input  o_retired_count, o_mispredict_count
    );

    modport slave (
        input  i_alloc_valid, i_alloc_pc, i_alloc_prediction, i_alloc_recovery_target,
        input  i_res_valid, i_res_tag, i_res_outcome, i_flush,
        output o_alloc_ready, o_alloc_tag, o_fb_valid, o_fb_pc, o_fb_prediction,
        output o_fb_outcome, o_redirect_valid, o_redirect_target, o_count,
        output o_retired_count, o_mispredict_count
    );
endinterface

// File: rtl/branch_resolution_queue.sv
// In-order branch resolution queue: allocates in program order, resolves by
// tag out of order, retires one resolved head entry per cycle to the
// predictor feedback port and redirects/squashes on a retired mispredict.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_resolution_queue
    import brq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    branch_resolution_queue_if.slave  bus
);

    localparam int             AW   = `ADDR_WIDTH;
    localparam logic [TAG_W:0] FULL = (TAG_W + 1)'(DEPTH);

    // pointers wrap naturally because DEPTH is a power of two
    function automatic logic [TAG_W-1:0] ptr_next(input logic [TAG_W-1:0] p);
        return p + TAG_W'(1);
    endfunction

    // entry control state
    logic [DEPTH-1:0]  ent_vld;
    logic [DEPTH-1:0]  ent_res;
    // entry payload, never reset: an invalid entry's payload is don't-care
    logic [AW-1:0]     ent_pc   [DEPTH];
    logic [AW-1:0]     ent_tgt  [DEPTH];
    BranchOutcome      ent_pred [DEPTH];
    BranchOutcome      ent_out  [DEPTH];

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    cnt;

    logic              retire_p0;
    logic              mispredict_p0;
    logic              squash_p0;
    logic              alloc_we_p0;
    logic              res_we_p0;

    logic              fb_vld_p1;
    logic              redir_vld_p1;
    logic [AW-1:0]     fb_pc_p1;
    BranchOutcome      fb_pred_p1;
    BranchOutcome      fb_out_p1;
    logic [AW-1:0]     redir_tgt_p1;
    logic [31:0]       ret_cnt;
    logic [31:0]       mis_cnt;

    // ---- stage p0: decisions from registered state and this cycle's requests
    // Derive retire/mispredict and which requests survive a squash this cycle.
    always_comb begin
        retire_p0     = ent_vld[head] & ent_res[head];
        mispredict_p0 = retire_p0 & (ent_out[head] != ent_pred[head]);
        squash_p0     = bus.i_flush | mispredict_p0;
        alloc_we_p0   = bus.i_alloc_valid & (cnt != FULL) & ~squash_p0;
        res_we_p0     = bus.i_res_valid & ent_vld[bus.i_res_tag] & ~squash_p0;
    end

    // Queue control: valid/resolved bits, pointers, occupancy, pulses, statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_vld      <= '0;
            ent_res      <= '0;
            head         <= '0;
            tail         <= '0;
            cnt          <= '0;
            fb_vld_p1    <= 1'b0;
            redir_vld_p1 <= 1'b0;
            ret_cnt      <= '0;
            mis_cnt      <= '0;
        end else if (bus.i_flush) begin
            ent_vld      <= '0;
            ent_res      <= '0;
            head         <= '0;
            tail         <= '0;
            cnt          <= '0;
            fb_vld_p1    <= 1'b0;
            redir_vld_p1 <= 1'b0;
        end else begin
            fb_vld_p1    <= retire_p0;
            redir_vld_p1 <= mispredict_p0;
            if (retire_p0)
                ret_cnt <= ret_cnt + 32'd1;
            if (mispredict_p0) begin
                mis_cnt <= mis_cnt + 32'd1;
                ent_vld <= '0;
                ent_res <= '0;
                head    <= '0;
                tail    <= '0;
                cnt     <= '0;
            end else begin
                if (res_we_p0)
                    ent_res[bus.i_res_tag] <= 1'b1;
                // retirement clears the head after any same-cycle resolution of it
                if (retire_p0) begin
                    ent_vld[head] <= 1'b0;
                    ent_res[head] <= 1'b0;
                    head          <= ptr_next(head);
                end
                if (alloc_we_p0) begin
                    ent_vld[tail] <= 1'b1;
                    ent_res[tail] <= 1'b0;
                    tail          <= ptr_next(tail);
                end
                case ({alloc_we_p0, retire_p0})
                    2'b10:   cnt <= cnt + (TAG_W + 1)'(1);
                    2'b01:   cnt <= cnt - (TAG_W + 1)'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // Entry payload capture on allocation and resolution.
    always_ff @(posedge clk) begin
        if (alloc_we_p0) begin
            ent_pc[tail]   <= bus.i_alloc_pc;
            ent_pred[tail] <= bus.i_alloc_prediction;
            ent_tgt[tail]  <= bus.i_alloc_recovery_target;
        end
        if (res_we_p0)
            ent_out[bus.i_res_tag] <= bus.i_res_outcome;
    end

    // ---- stage p1: registered feedback/redirect payload, held between pulses
    // Capture the retiring head entry for the predictor and the redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_pc_p1     <= '0;
            fb_pred_p1   <= NOT_TAKEN;
            fb_out_p1    <= NOT_TAKEN;
            redir_tgt_p1 <= '0;
        end else if (!bus.i_flush && retire_p0) begin
            fb_pc_p1   <= ent_pc[head];
            fb_pred_p1 <= ent_pred[head];
            fb_out_p1  <= ent_out[head];
            if (mispredict_p0)
                redir_tgt_p1 <= ent_tgt[head];
        end
    end

    assign bus.o_alloc_ready      = (cnt != FULL);
    assign bus.o_alloc_tag        = tail;
    assign bus.o_count            = cnt;
    assign bus.o_fb_valid         = fb_vld_p1;
    assign bus.o_fb_pc            = fb_pc_p1;
    assign bus.o_fb_prediction    = fb_pred_p1;
    assign bus.o_fb_outcome       = fb_out_p1;
    assign bus.o_redirect_valid   = redir_vld_p1;
    assign bus.o_redirect_target  = redir_tgt_p1;
    assign bus.o_retired_count    = ret_cnt;
    assign bus.o_mispredict_count = mis_cnt;

endmodule

// File: doc/branch_resolution_queue.md
# branch_resolution_queue

In-order tracking queue for conditional branches between decode and the branch predictor feedback port. Decode allocates one entry per predicted conditional branch (pc, prediction, recovery target); execute resolves entries out of order by tag. The queue retires resolved entries strictly in program order and drives the predictor feedback stream (valid / pc / prediction / outcome) one entry per cycle. On a retired misprediction it issues a single-cycle redirect to the recovery target and squashes all younger entries.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥ 2
- TAG_W, $clog2(DEPTH), tag / pointer width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; **one clock; reset is synchronous and active-low**
- i_alloc_valid  in  1  decode requests allocation (conditional branch, not jump)
- i_alloc_pc  in  `ADDR_WIDTH  branch pc
- i_alloc_prediction  in  BranchOutcome  predicted direction
- i_alloc_recovery_target  in  `ADDR_WIDTH  fetch address if prediction is wrong
- o_alloc_ready  out  1  queue can accept an allocation this cycle
- o_alloc_tag  out  TAG_W  tag assigned to an allocation accepted this cycle (tail pointer)
- i_res_valid  in  1  execute resolves a branch
- i_res_tag  in  TAG_W  tag being resolved
- i_res_outcome  in  BranchOutcome  actual direction
- i_flush  in  1  external squash of all entries
- o_fb_valid  out  1  feedback pulse to predictor
- o_fb_pc  out  `ADDR_WIDTH  retired branch pc
- o_fb_prediction  out  BranchOutcome  retired prediction
- o_fb_outcome  out  BranchOutcome  retired outcome
- o_redirect_valid  out  1  misprediction redirect pulse
- o_redirect_target  out  `ADDR_WIDTH  recovery target of mispredicted branch
- o_count  out  TAG_W+1  occupied entries
- o_retired_count  out  32  total retired branches, wraps
- o_mispredict_count  out  32  total retired mispredictions, wraps

## Operation
- Per entry: valid, resolved, pc, prediction, outcome, recovery_target. head/tail pointers of TAG_W bits wrap modulo DEPTH; count is TAG_W+1 bits.
- Allocation accepted when i_alloc_valid & o_alloc_ready; o_alloc_ready = (count != DEPTH), from registered count only (a retirement in the same cycle does not free a slot for that cycle). Accepted entry written at tail, valid=1, resolved=0; tail increments.
- Resolution: if i_res_valid and entry[i_res_tag].valid, set resolved=1 and store outcome. Resolution to an invalid entry is ignored. Re-resolution of an unretired entry overwrites outcome.
- Retirement: when entry[head] is valid and resolved (registered state), at that edge: entry cleared, head increments, o_fb_* registered from the entry, o_retired_count += 1. At most one retirement per cycle.
- Mispredict = outcome != prediction at retirement: additionally o_redirect_valid=1, o_redirect_target = recovery_target, o_mispredict_count += 1, and at the same edge all entries invalidated, head = tail = 0, count = 0. A simultaneous allocation or resolution is discarded.
- i_flush: at that edge all entries invalidated, head = tail = count = 0; no feedback or redirect emitted; concurrent allocation, resolution and retirement discarded. Counters unchanged.
- Simultaneous alloc + non-mispredict retire: count unchanged. Alloc only: +1. Retire only: −1.

## Timing
- Reset: all entries invalid, head = tail = 0, count = 0, o_alloc_ready = 1, o_alloc_tag = 0, o_fb_valid = 0, o_redirect_valid = 0, o_fb_pc = o_redirect_target = 0, o_fb_prediction = o_fb_outcome = NOT_TAKEN, both statistics counters = 0. Reset asserted mid-operation has the same effect and overrides i_flush.
- o_alloc_ready, o_alloc_tag, o_count: functions of registered state; stable through the cycle.
- Resolution sampled at edge E → earliest retirement at edge E+1 → o_fb_valid (and o_redirect_valid if mispredicted) high during the cycle after E+1, for exactly one cycle per retired entry.
- Back-to-back resolved entries retire on consecutive edges; o_fb_valid stays high continuously.
- o_fb_pc/prediction/outcome and o_redirect_target hold last value when the valid pulse is low.

## Test plan
- Reset then allocate pc 0x100 (TAKEN), 0x104 (NOT_TAKEN) → tags 0, 1, o_count 2; resolve tag 0 TAKEN → two edges later o_fb_valid 1 cycle, pc 0x100, no redirect, o_retired_count 1.
- Out of order: allocate tags 0..2, resolve 2 then 1 then 0 (outcome = prediction) → feedback pulses in order 0,1,2 on three consecutive cycles after tag 0 resolves.
- Fill to DEPTH=8 → o_alloc_ready 0, further i_alloc_valid ignored (o_count stays 8); retire one → o_alloc_ready 1 next cycle; tail wraps to tag 0.
- Mispredict: allocate tags 0..3, tag 0 predicted NOT_TAKEN, recovery 0x208; resolve tag 0 TAKEN with alloc asserted on the retire edge → o_redirect_valid + o_fb_valid 1 cycle, target 0x208, o_count 0, o_mispredict_count 1, allocation dropped; next allocation gets tag 0.
- i_flush with 3 resolved entries pending → no feedback, o_count 0, counters unchanged; resolution of stale tag afterwards ignored.
- rst_n low mid-stream with entries pending and i_flush high → all outputs at reset values next cycle.
